alu_imm_ctrl: RTL and testbench
===============================

// Module: alu_imm_ctrl
// PURPOSE
//  Parametrised control FSM for register-immediate ALU instructions (ADDI/SUBI/ANDI/ORI).
//  Captures the instruction on a start/busy/done handshake and sequences the shared bus.
//  Bus sequence: Rd -> ALU in0, zero-extended imm -> ALU in1, ALU op, latch, result -> Rd.
//  Sits beside the other instruction FSMs under the top-level decoder; drives tri-state enables only.
// PARAMETERS
//  DATA_W    16  bus / immediate-output width
//  NREG      6   number of general registers (one-hot enable width), 1..2**SEL_W
//  SEL_W     6   register-select field width, instruction[IMM_W+SEL_W-1:IMM_W]
//  IMM_W     6   immediate field width, instruction[IMM_W-1:0]; IMM_W <= DATA_W
//  OPC_W     4   opcode width, instruction[OPC_W+SEL_W+IMM_W-1 : SEL_W+IMM_W]
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       synchronous reset, active-high
//  start         in   1       instruction valid; accepted only in IDLE
//  instruction   in   OPC_W+SEL_W+IMM_W   instruction word, sampled when start accepted
//  busy          out  1       high from cycle after accept until done/illegal cycle inclusive
//  done          out  1       one-cycle pulse, instruction retired
//  illegal       out  1       one-cycle pulse with done, bad opcode or register index
//  rx_out        out  NREG    one-hot register output enable (MSB = reg 0)
//  rx_in         out  NREG    one-hot register load enable (MSB = reg 0)
//  alu_in0       out  1       ALU operand-A latch
//  alu_in1       out  1       ALU operand-B latch
//  alu_op        out  2       00 ADD, 01 SUB, 10 AND, 11 OR; valid EXEC..LATCH
//  alu_out_latch out  1       ALU result register latch
//  alu_out_en    out  1       ALU result tri-state enable
//  imm_en        out  1       immediate tri-state enable
//  imm_out       out  DATA_W  extended immediate, held from accept until IDLE
//  pc_inc        out  1       one-cycle PC increment pulse
// BEHAVIOUR
//  Reset: state IDLE, every output 0, captured instruction cleared. Reset mid-op aborts, no write.
//  All outputs registered-state decoded (Moore); no output depends combinationally on start.
//  IDLE  : start=1 -> capture instruction, decode -> (legal ? RD_A : ERR).
//  RD_A  : rx_out=onehot(sel), pc_inc=1                 -> LD_A
//  LD_A  : rx_out=onehot(sel), alu_in0=1                -> IMM
//  IMM   : imm_en=1                                     -> LD_B
//  LD_B  : imm_en=1, alu_in1=1                          -> EXEC
//  EXEC  : alu_op valid                                 -> LATCH
//  LATCH : alu_op valid, alu_out_latch=1                -> WB
//  WB    : alu_out_en=1, rx_in=onehot(sel)              -> DONE
//  DONE  : done=1                                       -> IDLE
//  ERR   : done=1, illegal=1, pc_inc=1                  -> IDLE (no bus, no reg write)
//  Latency: start accepted at edge N -> done high in cycle N+8 (legal), N+1 (illegal).
//  Back-to-back: start may be high in DONE; it is accepted only on the next IDLE cycle.
//  start while busy ignored; instruction changes after accept ignored.
//  Legal: opcode in {ADDI,SUBI,ANDI,ORI} and sel < NREG; otherwise ERR.
//  Exactly one rx_out/rx_in bit high when asserted; never rx_out and rx_in same cycle.
//  Never two bus drivers (rx_out, imm_en, alu_out_en) in one cycle.
// CONFIGURATION
//  ALU_IMM_SIGN_EXT_EN defined: imm_out = sign-extended imm (replicate bit IMM_W-1) for ADDI/SUBI;
//    ANDI/ORI still zero-extended.
//  Not defined: imm_out = {DATA_W-IMM_W zeros, imm} for all opcodes.
// STRUCTURE
//  Package alu_imm_pkg: state enum (IDLE..ERR, 4-bit), opcode constants
//    (ADDI=1, SUBI=2, ANDI=3, ORI=4), alu_op encodings.
//  Sub-module onehot_dec #(N,W): binary sel -> N-bit one-hot (MSB = index 0) plus in_range flag.
//    Instantiated once, used for both rx_out and rx_in.
// TESTING
//  ADDI r2,#5 (sel=2, NREG=6): rx_out=001000 cycles 1-2, imm_out=0x0005, rx_in=001000 cycle 7,
//    done cycle 8.
//  Opcode 0xF: illegal=done=1 cycle 1, pc_inc=1, rx_in/rx_out stay 0.
//  sel=6 with NREG=6: illegal path, no bus activity.
//  rst asserted in LATCH: next cycle all outputs 0; later start runs a full clean 8-cycle sequence.
//  start held high across two ops: second op accepted the cycle after DONE; start while busy ignored.
//  SUBI imm=6'h3F: imm_out=0xFFFF with ALU_IMM_SIGN_EXT_EN, 0x003F without; alu_op=01.

Source files
------------

// File: rtl/alu_imm_ctrl_pkg.sv
// Shared types and constants for the register-immediate ALU instruction controller.
package alu_imm_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_RD_A  = 4'd1,
    S_LD_A  = 4'd2,
    S_IMM   = 4'd3,
    S_LD_B  = 4'd4,
    S_EXEC  = 4'd5,
    S_LATCH = 4'd6,
    S_WB    = 4'd7,
    S_DONE  = 4'd8,
    S_ERR   = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  localparam int unsigned OPC_ADDI = 1;
  localparam int unsigned OPC_SUBI = 2;
  localparam int unsigned OPC_ANDI = 3;
  localparam int unsigned OPC_ORI  = 4;

endpackage

// File: rtl/alu_imm_ctrl_if.sv
// Instruction handshake and shared-bus control signals of the immediate ALU controller.
interface alu_imm_ctrl_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 6,
  parameter int unsigned SEL_W  = 6,
  parameter int unsigned IMM_W  = 6,
  parameter int unsigned OPC_W  = 4
);
  localparam int unsigned INSTR_W = OPC_W + SEL_W + IMM_W;

  logic               start;
  logic [INSTR_W-1:0] instruction;
  logic               busy;
  logic               done;
  logic               illegal;
  logic [NREG-1:0]    rx_out;
  logic [NREG-1:0]    rx_in;
  logic               alu_in0;
  logic               alu_in1;
  logic [1:0]         alu_op;
  logic               alu_out_latch;
  logic               alu_out_en;
  logic               imm_en;
  logic [DATA_W-1:0]  imm_out;
  logic               pc_inc;

  modport master (
    output start, instruction,
    input  busy, done, illegal, rx_out, rx_in, alu_in0, alu_in1, alu_op,
           alu_out_latch, alu_out_en, imm_en, imm_out, pc_inc
  );

  modport slave (
    input  start, instruction,
    output busy, done, illegal, rx_out, rx_in, alu_in0, alu_in1, alu_op,
           alu_out_latch, alu_out_en, imm_en, imm_out, pc_inc
  );
endinterface

// File: rtl/alu_imm_ctrl_onehot_dec.sv
// Binary select to one-hot enable (MSB = index 0) with an in-range flag.
module onehot_dec #(
  parameter int unsigned N = 6,
  parameter int unsigned W = 6
) (
  input  logic [W-1:0] sel,
  output logic [N-1:0] onehot_c,
  output logic         in_range_c
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign onehot_c[N-1-i] = (sel == W'(i));
  end

  assign in_range_c = ({1'b0, sel} < (W+1)'(N));

endmodule

// File: rtl/alu_imm_ctrl.sv
// Control FSM sequencing the shared bus for ADDI/SUBI/ANDI/ORI.
// Optional ALU_IMM_SIGN_EXT_EN: sign-extend the immediate for ADDI/SUBI.
module alu_imm_ctrl
  import alu_imm_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 6,
  parameter int unsigned SEL_W  = 6,
  parameter int unsigned IMM_W  = 6,
  parameter int unsigned OPC_W  = 4
) (
  input logic           clk,
  input logic           rst,
  alu_imm_ctrl_if.slave bus
);

  localparam int unsigned INSTR_W = OPC_W + SEL_W + IMM_W;

  state_t            state_q, state_d;
  logic [OPC_W-1:0]  opc_q, opc_in;
  logic [SEL_W-1:0]  sel_q, sel_in, sel_dec;
  logic [IMM_W-1:0]  imm_in;
  logic [DATA_W-1:0] imm_ext_c;
  logic [NREG-1:0]   sel_oh_c;
  logic              sel_ok_c, opc_ok_c, accept_c;
  alu_op_t           alu_sel_c;

  logic              busy_d, done_d, illegal_d, pc_inc_d;
  logic              alu_in0_d, alu_in1_d, alu_out_latch_d, alu_out_en_d, imm_en_d;
  logic [NREG-1:0]   rx_out_d, rx_in_d;
  logic [1:0]        alu_op_d;
  logic [DATA_W-1:0] imm_d;

  assign opc_in   = bus.instruction[INSTR_W-1 -: OPC_W];
  assign sel_in   = bus.instruction[IMM_W +: SEL_W];
  assign imm_in   = bus.instruction[IMM_W-1:0];
  assign accept_c = (state_q == S_IDLE) && bus.start;
  assign opc_ok_c = opc_in inside {OPC_W'(OPC_ADDI), OPC_W'(OPC_SUBI),
                                   OPC_W'(OPC_ANDI), OPC_W'(OPC_ORI)};

  // Decode the select that will be live next cycle: fresh at accept, captured otherwise.
  assign sel_dec = accept_c ? sel_in : sel_q;

  onehot_dec #(.N(NREG), .W(SEL_W)) u_dec (
    .sel        (sel_dec),
    .onehot_c   (sel_oh_c),
    .in_range_c (sel_ok_c)
  );

  always_comb begin
    imm_ext_c = DATA_W'(imm_in);
`ifdef ALU_IMM_SIGN_EXT_EN
    if (opc_in == OPC_W'(OPC_ADDI) || opc_in == OPC_W'(OPC_SUBI))
      imm_ext_c = DATA_W'($signed(imm_in));
`endif
  end

  always_comb begin
    case (opc_q)
      OPC_W'(OPC_SUBI): alu_sel_c = ALU_SUB;
      OPC_W'(OPC_ANDI): alu_sel_c = ALU_AND;
      OPC_W'(OPC_ORI):  alu_sel_c = ALU_OR;
      default:          alu_sel_c = ALU_ADD;
    endcase
  end

  // Next state, then the Moore outputs of that next state so they can be registered.
  always_comb begin
    state_d         = state_q;
    busy_d          = 1'b0;
    done_d          = 1'b0;
    illegal_d       = 1'b0;
    pc_inc_d        = 1'b0;
    alu_in0_d       = 1'b0;
    alu_in1_d       = 1'b0;
    alu_out_latch_d = 1'b0;
    alu_out_en_d    = 1'b0;
    imm_en_d        = 1'b0;
    rx_out_d        = '0;
    rx_in_d         = '0;
    alu_op_d        = 2'b00;
    imm_d           = bus.imm_out;

    case (state_q)
      S_IDLE:  if (bus.start) state_d = (opc_ok_c && sel_ok_c) ? S_RD_A : S_ERR;
      S_RD_A:  state_d = S_LD_A;
      S_LD_A:  state_d = S_IMM;
      S_IMM:   state_d = S_LD_B;
      S_LD_B:  state_d = S_EXEC;
      S_EXEC:  state_d = S_LATCH;
      S_LATCH: state_d = S_WB;
      S_WB:    state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_RD_A:  begin rx_out_d = sel_oh_c; pc_inc_d = 1'b1; end
      S_LD_A:  begin rx_out_d = sel_oh_c; alu_in0_d = 1'b1; end
      S_IMM:   imm_en_d = 1'b1;
      S_LD_B:  begin imm_en_d = 1'b1; alu_in1_d = 1'b1; end
      S_EXEC:  alu_op_d = alu_sel_c;
      S_LATCH: begin alu_op_d = alu_sel_c; alu_out_latch_d = 1'b1; end
      S_WB:    begin alu_out_en_d = 1'b1; rx_in_d = sel_oh_c; end
      S_DONE:  done_d = 1'b1;
      S_ERR:   begin done_d = 1'b1; illegal_d = 1'b1; pc_inc_d = 1'b1; end
      default: ;
    endcase

    busy_d = (state_d != S_IDLE);
    if (accept_c)              imm_d = imm_ext_c;
    else if (state_d == S_IDLE) imm_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      opc_q             <= '0;
      sel_q             <= '0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.illegal       <= 1'b0;
      bus.pc_inc        <= 1'b0;
      bus.alu_in0       <= 1'b0;
      bus.alu_in1       <= 1'b0;
      bus.alu_out_latch <= 1'b0;
      bus.alu_out_en    <= 1'b0;
      bus.imm_en        <= 1'b0;
      bus.rx_out        <= '0;
      bus.rx_in         <= '0;
      bus.alu_op        <= 2'b00;
      bus.imm_out       <= '0;
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        opc_q <= opc_in;
        sel_q <= sel_in;
      end
      bus.busy          <= busy_d;
      bus.done          <= done_d;
      bus.illegal       <= illegal_d;
      bus.pc_inc        <= pc_inc_d;
      bus.alu_in0       <= alu_in0_d;
      bus.alu_in1       <= alu_in1_d;
      bus.alu_out_latch <= alu_out_latch_d;
      bus.alu_out_en    <= alu_out_en_d;
      bus.imm_en        <= imm_en_d;
      bus.rx_out        <= rx_out_d;
      bus.rx_in         <= rx_in_d;
      bus.alu_op        <= alu_op_d;
      bus.imm_out       <= imm_d;
    end
  end

endmodule

// File: tb/tb_alu_imm_ctrl.sv
// Randomized self-checking bench for alu_imm_ctrl against a per-cycle schedule model.
module tb_alu_imm_ctrl;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned NREG    = 6;
  localparam int unsigned SEL_W   = 6;
  localparam int unsigned IMM_W   = 6;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned INSTR_W = OPC_W + SEL_W + IMM_W;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_imm_ctrl_if #(.DATA_W(DATA_W), .NREG(NREG), .SEL_W(SEL_W), .IMM_W(IMM_W), .OPC_W(OPC_W)) bus ();

  alu_imm_ctrl #(.DATA_W(DATA_W), .NREG(NREG), .SEL_W(SEL_W), .IMM_W(IMM_W), .OPC_W(OPC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected outputs k cycles after accept (k=0: idle / reset).
  task automatic check_cycle(input int k, input bit legal, input int opc,
                             input logic [NREG-1:0] oh, input logic [DATA_W-1:0] e_imm);
    logic [8:0] e_ctrl, o_ctrl;
    logic [NREG-1:0] e_rxo, e_rxi;
    logic [1:0] e_op;
    bit b, d, il, pc, i0, i1, lt, oe, ie;
    b = (k >= 1); d = 0; il = 0; pc = 0; i0 = 0; i1 = 0; lt = 0; oe = 0; ie = 0;
    e_rxo = '0; e_rxi = '0; e_op = 2'b00;
    if (k >= 1 && legal) begin
      pc = (k == 1); i0 = (k == 2); ie = (k == 3 || k == 4); i1 = (k == 4);
      lt = (k == 6); oe = (k == 7); d = (k == 8);
      if (k == 1 || k == 2) e_rxo = oh;
      if (k == 7) e_rxi = oh;
      if (k == 5 || k == 6) e_op = 2'(opc - 1);
    end else if (k == 1) begin
      d = 1; il = 1; pc = 1;
    end
    e_ctrl = {b, d, il, pc, i0, i1, lt, oe, ie};
    o_ctrl = {bus.busy, bus.done, bus.illegal, bus.pc_inc, bus.alu_in0, bus.alu_in1,
              bus.alu_out_latch, bus.alu_out_en, bus.imm_en};
    check($sformatf("ctrl op%0d k%0d", opc, k), 64'(o_ctrl), 64'(e_ctrl));
    check($sformatf("rx_out op%0d k%0d", opc, k), 64'(bus.rx_out), 64'(e_rxo));
    check($sformatf("rx_in op%0d k%0d", opc, k), 64'(bus.rx_in), 64'(e_rxi));
    check($sformatf("alu_op op%0d k%0d", opc, k), 64'(bus.alu_op), 64'(e_op));
    check($sformatf("imm_out op%0d k%0d", opc, k), 64'(bus.imm_out),
          64'((k >= 1) ? e_imm : '0));
  endtask

  // Called at a negedge of an idle cycle; returns at a negedge of an idle cycle.
  task automatic run_op(input int opc, input int sel, input int imm, input int rst_at,
                        input bit hold_start);
    bit legal;
    int k_last;
    logic [NREG-1:0] oh;
    logic [DATA_W-1:0] e_imm;
    legal  = (opc >= 1 && opc <= 4) && (sel < int'(NREG));
    k_last = legal ? 8 : 1;
    oh     = legal ? (NREG'(1) << (int'(NREG) - 1 - sel)) : '0;
    e_imm  = DATA_W'(imm);
`ifdef ALU_IMM_SIGN_EXT_EN
    if ((opc == 1 || opc == 2) && imm >= (1 << (IMM_W - 1)))
      e_imm = DATA_W'(imm + (1 << DATA_W) - (1 << IMM_W));
`endif
    bus.start       = 1'b1;
    bus.instruction = INSTR_W'((opc << (SEL_W + IMM_W)) | (sel << IMM_W) | imm);
    for (int k = 1; k <= k_last; k++) begin
      @(negedge clk);
      check_cycle(k, legal, opc, oh, e_imm);
      if (k == rst_at) begin
        rst = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check_cycle(0, legal, opc, oh, e_imm);
        rst = 1'b0;
        return;
      end
      bus.start       = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
      bus.instruction = INSTR_W'($urandom);
    end
    @(negedge clk);
    check_cycle(0, legal, opc, oh, e_imm);
    bus.start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.instruction = '0;
    repeat (3) @(negedge clk);
    check_cycle(0, 1'b0, 0, '0, '0);
    rst = 1'b0;
    @(negedge clk);

    run_op(1, 2, 5, 0, 1'b0);    // ADDI r2,#5
    run_op(15, 1, 3, 0, 1'b0);   // bad opcode
    run_op(1, 6, 7, 0, 1'b0);    // register index out of range
    run_op(0, 0, 9, 0, 1'b0);    // opcode 0 is not an instruction
    run_op(2, 3, 63, 0, 1'b0);   // SUBI with all-ones immediate
    run_op(3, 0, 21, 6, 1'b0);   // reset while in LATCH
    run_op(4, 5, 9, 0, 1'b0);    // clean run after abort
    run_op(4, 5, 9, 0, 1'b1);    // start held across back-to-back ops
    run_op(1, 1, 33, 0, 1'b1);
    run_op(2, 0, 40, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      int opc, sel, imm;
      opc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 4));
      sel = int'($urandom_range(0, 7));
      imm = int'($urandom_range(0, 63));
      run_op(opc, sel, imm, 0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
